// File: rtl/gcn_result_streamer.sv
// Output stage of the GCN accelerator: buffers one pass of 2 x ROWS result words
// and streams a header plus all words as one framed burst when the core finishes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting core writes, waiting for i_done
// HDR    | column indices latched; header word loads at the next edge
// STREAM | word k loads each edge (col 0 rows, then col 1 rows)
module gcn_result_streamer #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [6:0]        wr_row,
    input  logic              wr_col_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [7:0]        i_col1,
    input  logic [7:0]        i_col2,
    input  logic              i_done,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_rdy,
    output logic              o_result,
    output logic [DATA_W-1:0] o_data
);

    localparam int               K_W    = $clog2(2 * ROWS);
    localparam logic [K_W-1:0]   K_LAST = K_W'(2 * ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_STREAM
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [K_W-1:0]    k_q;
    logic [7:0]        col1_q;
    logic [7:0]        col2_q;
    logic [2*ROWS-1:0] flag_q;
    logic [DATA_W-1:0] mem [2*ROWS];

    logic              idle;
    logic              wr_ok;
    logic              start;
    logic              err_set;
    logic              last_word;
    logic [K_W-1:0]    wr_idx;
    logic [DATA_W-1:0] data_d;

    // Both columns share one flat index space: col 1 row r lives at ROWS + r,
    // which is also the stream word number k.
    always_comb begin
        idle      = (state_q == S_IDLE);
        wr_ok     = idle && wr_en && (int'(wr_row) < ROWS);
        start     = idle && i_done;
        err_set   = (wr_en && !wr_ok) || (i_done && !idle);
        last_word = (state_q == S_STREAM) && (k_q == K_LAST);
        wr_idx    = wr_col_sel ? K_W'(ROWS) + K_W'(wr_row) : K_W'(wr_row);

        state_d = state_q;
        data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                state_d = S_STREAM;
                data_d  = DATA_W'({col2_q, col1_q});
            end
            S_STREAM: begin
                if (last_word) state_d = S_IDLE;
                data_d = flag_q[k_q] ? mem[k_q] : '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q      <= '0;
            col1_q   <= '0;
            col2_q   <= '0;
            flag_q   <= '0;
            o_rdy    <= 1'b0;
            o_result <= 1'b1;
            o_data   <= '0;
            o_busy   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            k_q <= (state_q == S_STREAM) ? k_q + K_W'(1) : '0;
            if (start) begin
                col1_q <= i_col1;
                col2_q <= i_col2;
            end
            if (last_word) flag_q <= '0;
            if (wr_ok)     flag_q[wr_idx] <= 1'b1;
            o_rdy    <= !idle;
            o_result <= idle;
            o_busy   <= !idle;
            o_data   <= data_d;
            o_err    <= o_err | err_set;
        end
    end

    // Result storage needs no reset; the written-flags gate every read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= wr_data;
    end

endmodule

// File: tb/tb_gcn_result_streamer.sv
// Scoreboard bench for gcn_result_streamer: stimulus pushes expected frame words,
// a negedge monitor pops and compares whenever o_rdy is high.
module tb_gcn_result_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_row = '0;
    logic        wr_col_sel = 1'b0;
    logic [15:0] wr_data = '0;
    logic [7:0]  i_col1 = '0;
    logic [7:0]  i_col2 = '0;
    logic        i_done = 1'b0;
    logic        o_busy;
    logic        o_err;
    logic        o_rdy;
    logic        o_result;
    logic [15:0] o_data;

    gcn_result_streamer #(.DATA_W(16), .ROWS(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col_sel (wr_col_sel),
        .wr_data    (wr_data),
        .i_col1     (i_col1),
        .i_col2     (i_col2),
        .i_done     (i_done),
        .o_busy     (o_busy),
        .o_err      (o_err),
        .o_rdy      (o_rdy),
        .o_result   (o_result),
        .o_data     (o_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          run_len = 0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;
    logic [15:0] m_mem[200];
    bit          m_flag[200];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (o_rdy) begin
                chk("frame_result_low", 32'(o_result), 32'd0);
                chk("frame_busy", 32'(o_busy), 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got %0h expected none at %0t", o_data, $time);
                end else begin
                    mon_exp = sb.pop_front();
                    chk("frame_word", 32'(o_data), 32'(mon_exp));
                end
                run_len++;
            end else begin
                if (run_len != 0) chk("frame_len", 32'(run_len), 32'd201);
                run_len = 0;
                chk("idle_result", 32'(o_result), 32'd1);
                chk("idle_data", 32'(o_data), 32'd0);
                chk("idle_busy", 32'(o_busy), 32'd0);
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic wr(input logic col, input logic [6:0] row, input logic [15:0] data);
        wr_en = 1'b1; wr_col_sel = col; wr_row = row; wr_data = data;
        if (row < 7'd100) begin
            m_mem[int'(col) * 100 + int'(row)]  = data;
            m_flag[int'(col) * 100 + int'(row)] = 1'b1;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // viol_k/rst_k: word index at which to inject a violation or a reset (-1 = none).
    // b2b: return one edge early so the next drive lands on the first legal edge.
    task automatic run_pass(input logic [7:0] c1, input logic [7:0] c2,
                            input int viol_k, input int rst_k, input bit b2b,
                            input bit co_wr, input logic co_col,
                            input logic [6:0] co_row, input logic [15:0] co_data);
        int last;
        if (co_wr) begin
            wr_en = 1'b1; wr_col_sel = co_col; wr_row = co_row; wr_data = co_data;
            m_mem[int'(co_col) * 100 + int'(co_row)]  = co_data;
            m_flag[int'(co_col) * 100 + int'(co_row)] = 1'b1;
        end
        sb.push_back({c2, c1});
        for (int j = 0; j < 200; j++) sb.push_back(m_flag[j] ? m_mem[j] : 16'h0000);
        for (int j = 0; j < 200; j++) m_flag[j] = 1'b0;
        i_col1 = c1; i_col2 = c2; i_done = 1'b1;
        @(posedge clk); #1;
        i_done = 1'b0; wr_en = 1'b0;
        last = b2b ? 201 : 202;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk); #1;
            wr_en = 1'b0; i_done = 1'b0;
            if (viol_k >= 0 && n == viol_k + 2) begin
                wr_en = 1'b1; wr_col_sel = 1'b0; wr_row = 7'd0; wr_data = 16'hFFFF;
                i_col1 = 8'hEE; i_col2 = 8'hDD; i_done = 1'b1;
            end
            if (rst_k >= 0 && n == rst_k + 2) begin
                #2 rst = 1'b0;
                #1;
                chk("async_rst_rdy", 32'(o_rdy), 32'd0);
                chk("async_rst_result", 32'(o_result), 32'd1);
                chk("async_rst_busy", 32'(o_busy), 32'd0);
                sb.delete();
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 200; j++) begin m_mem[j] = '0; m_flag[j] = 1'b0; end

        // reset with inputs toggling
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            wr_en = ~wr_en; i_done = ~i_done;
        end
        chk("rst_rdy", 32'(o_rdy), 32'd0);
        chk("rst_result", 32'(o_result), 32'd1);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        wr_en = 1'b0; i_done = 1'b0;
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // full pass
        for (int r = 0; r < 100; r++) begin
            wr(1'b0, 7'(r), 16'(r));
            wr(1'b1, 7'(r), 16'h1000 + 16'(r));
        end
        run_pass(8'd3, 8'd7, -1, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        chk("full_err", 32'(o_err), 32'd0);

        // sparse pass, then empty pass
        wr(1'b1, 7'd5, 16'hABCD);
        run_pass(8'd0, 8'd1, -1, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        run_pass(8'd2, 8'd3, -1, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        chk("sparse_err", 32'(o_err), 32'd0);

        // violations mid-frame
        wr(1'b0, 7'd0, 16'h1111);
        run_pass(8'd8, 8'd9, 50, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        chk("viol_err", 32'(o_err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        run_pass(8'd10, 8'd11, -1, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        chk("viol_err_sticky", 32'(o_err), 32'd1);

        // reset mid-stream
        wr(1'b1, 7'd30, 16'h4444);
        run_pass(8'd1, 8'd2, -1, 50, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);
        chk("midrst_err", 32'(o_err), 32'd0);
        run_pass(8'd4, 8'd5, -1, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);

        // out-of-range row while idle
        wr(1'b0, 7'd120, 16'h7777);
        chk("row_oor_err", 32'(o_err), 32'd1);
        run_pass(8'd5, 8'd6, -1, -1, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0);

        // write coincident with i_done, then back-to-back passes
        run_pass(8'd12, 8'd13, -1, -1, 1'b1, 1'b1, 1'b1, 7'd99, 16'h5A5A);
        for (int p = 0; p < 4; p++) begin
            wr(1'b0, 7'(p), 16'hA000 + 16'(p));
            run_pass(8'(2 * p), 8'(2 * p + 1), -1, -1, (p < 3), 1'b1, 1'b1,
                     7'(90 + p), 16'hB000 + 16'(p));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
